// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART transmit path.
//   state_t      - transmitter state encodings (3-bit)
//   PARITY_*     - values accepted by the PARITY parameter
//   frame_len()  - clock cycles occupied by one complete frame on the line
package uart_pkg;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } state_t;

   localparam int unsigned PARITY_NONE = 0;
   localparam int unsigned PARITY_EVEN = 1;
   localparam int unsigned PARITY_ODD  = 2;

   function automatic int unsigned frame_len(input int unsigned cpb,
                                             input int unsigned data_bits,
                                             input int unsigned parity,
                                             input int unsigned stop_bits);
      return cpb * (1 + data_bits + ((parity != PARITY_NONE) ? 1 : 0) + stop_bits);
   endfunction

endpackage

// File: rtl/uart_tx_fifo_param_if.sv
// uart_tx_fifo_param_if: producer-side write port of the FIFO-backed UART transmitter.
//   tx_dv      - write strobe, accepted when tx_ready is also high at the clock edge
//   tx_byte    - data word to write
//   tx_ready   - FIFO not full
//   fifo_count - words waiting in the FIFO (excludes the word on the line)
// master = producer, slave = transmitter.
interface uart_tx_fifo_param_if #(
   parameter int unsigned DATA_BITS  = 8,
   parameter int unsigned FIFO_DEPTH = 4
);
   logic                          tx_dv;
   logic [DATA_BITS-1:0]          tx_byte;
   logic                          tx_ready;
   logic [$clog2(FIFO_DEPTH):0]   fifo_count;

   modport master (output tx_dv, output tx_byte, input tx_ready, input fifo_count);
   modport slave  (input tx_dv, input tx_byte, output tx_ready, output fifo_count);
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: synchronous show-ahead FIFO, asynchronous active-high reset.
//   i_Clock, i_Reset - clock / async reset
//   i_Wr_En, i_Wr_Data - write port; ignored while full
//   i_Rd_En, o_Rd_Data - pop port; o_Rd_Data always presents the head word
//   o_Full, o_Empty, o_Count - status, all derived from the registered count
module uart_tx_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic                     i_Clock,
   input  logic                     i_Reset,
   input  logic                     i_Wr_En,
   input  logic [WIDTH-1:0]         i_Wr_Data,
   input  logic                     i_Rd_En,
   output logic [WIDTH-1:0]         o_Rd_Data,
   output logic                     o_Full,
   output logic                     o_Empty,
   output logic [$clog2(DEPTH):0]   o_Count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             push;
   logic             pop;

   assign o_Full    = (count == FULL_CNT);
   assign o_Empty   = (count == '0);
   assign push      = i_Wr_En & ~o_Full;
   assign pop       = i_Rd_En & ~o_Empty;
   assign o_Rd_Data = mem[rd_ptr];
   assign o_Count   = count;

   always_ff @(posedge i_Clock) begin
      if (push) mem[wr_ptr] <= i_Wr_Data;
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge i_Clock or posedge i_Reset) begin
      if (i_Reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/uart_tx_fifo_param.sv
// uart_tx_fifo_param: UART transmitter fed from an internal FIFO.
//   i_Clock, i_Reset - clock / async active-high reset
//   tx_if (slave)    - write strobe, data word, ready (FIFO not full), FIFO count
//   o_Tx_Active      - high from first start-bit cycle through last stop-bit cycle
//   o_Tx_Serial      - serial line, idles high
//   o_Tx_Done        - one-cycle pulse on the last stop cycle of each frame
// Frames: start, DATA_BITS LSB first, optional parity, STOP_BITS stop bits.
// Consecutive frames are sent with no idle gap while words are queued.
module uart_tx_fifo_param
   import uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 6,
   parameter int unsigned DATA_BITS    = 8,
   parameter int unsigned PARITY       = 0,
   parameter int unsigned STOP_BITS    = 1,
   parameter int unsigned FIFO_DEPTH   = 4
) (
   input  logic                  i_Clock,
   input  logic                  i_Reset,
   uart_tx_fifo_param_if.slave   tx_if,
   output logic                  o_Tx_Active,
   output logic                  o_Tx_Serial,
   output logic                  o_Tx_Done
);

   localparam int unsigned CNT_W    = $clog2(FIFO_DEPTH) + 1;
   localparam int unsigned STOP_LEN = STOP_BITS * CLKS_PER_BIT;
   localparam int unsigned STOP_W   = $clog2(STOP_LEN);

   localparam logic [11:0]       CYC_LAST  = 12'(CLKS_PER_BIT - 1);
   localparam logic [3:0]        BIT_LAST  = 4'(DATA_BITS - 1);
   localparam logic [STOP_W-1:0] STOP_LAST = STOP_W'(STOP_LEN - 1);
   localparam logic [STOP_W-1:0] STOP_PRE  = STOP_W'(STOP_LEN - 2);
   localparam logic              HAS_PAR   = (PARITY != PARITY_NONE);
   localparam logic              PAR_INV   = (PARITY == PARITY_ODD);

   logic                 fifo_pop;
   logic [DATA_BITS-1:0] fifo_data;
   logic                 fifo_full;
   logic                 fifo_empty;
   logic [CNT_W-1:0]     fifo_count;

   uart_tx_fifo #(
      .WIDTH (DATA_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .i_Clock   (i_Clock),
      .i_Reset   (i_Reset),
      .i_Wr_En   (tx_if.tx_dv),
      .i_Wr_Data (tx_if.tx_byte),
      .i_Rd_En   (fifo_pop),
      .o_Rd_Data (fifo_data),
      .o_Full    (fifo_full),
      .o_Empty   (fifo_empty),
      .o_Count   (fifo_count)
   );

   assign tx_if.tx_ready   = ~fifo_full;
   assign tx_if.fifo_count = fifo_count;

   state_t               state_q, state_d;
   logic [11:0]          cyc_q, cyc_d;
   logic [3:0]           bit_q, bit_d;
   logic [STOP_W-1:0]    stop_q, stop_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 par_q, par_d;
   logic                 serial_q, serial_d;
   logic                 active_q, active_d;
   logic                 done_q, done_d;

   always_ff @(posedge i_Clock or posedge i_Reset) begin
      if (i_Reset) begin
         state_q  <= S_IDLE;
         cyc_q    <= '0;
         bit_q    <= '0;
         stop_q   <= '0;
         shift_q  <= '0;
         par_q    <= 1'b0;
         serial_q <= 1'b1;
         active_q <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cyc_q    <= cyc_d;
         bit_q    <= bit_d;
         stop_q   <= stop_d;
         shift_q  <= shift_d;
         par_q    <= par_d;
         serial_q <= serial_d;
         active_q <= active_d;
         done_q   <= done_d;
      end
   end

   // Outputs are registered: serial_d/active_d/done_d describe the cycle that
   // follows the edge, so the line level is chosen from the state being entered.
   always_comb begin
      state_d  = state_q;
      cyc_d    = cyc_q;
      bit_d    = bit_q;
      stop_d   = stop_q;
      shift_d  = shift_q;
      par_d    = par_q;
      serial_d = serial_q;
      active_d = active_q;
      done_d   = 1'b0;
      fifo_pop = 1'b0;

      case (state_q)
         S_IDLE: begin
            serial_d = 1'b1;
            active_d = 1'b0;
            if (!fifo_empty) fifo_pop = 1'b1;
         end
         S_START: begin
            if (cyc_q == CYC_LAST) begin
               cyc_d    = '0;
               state_d  = S_DATA;
               serial_d = shift_q[0];
            end else begin
               cyc_d = cyc_q + 12'd1;
            end
         end
         S_DATA: begin
            if (cyc_q == CYC_LAST) begin
               cyc_d = '0;
               if (bit_q == BIT_LAST) begin
                  if (HAS_PAR) begin
                     state_d  = S_PARITY;
                     serial_d = par_q;
                  end else begin
                     state_d  = S_STOP;
                     serial_d = 1'b1;
                     stop_d   = '0;
                  end
               end else begin
                  bit_d    = bit_q + 4'd1;
                  shift_d  = shift_q >> 1;
                  serial_d = shift_d[0];
               end
            end else begin
               cyc_d = cyc_q + 12'd1;
            end
         end
         S_PARITY: begin
            if (cyc_q == CYC_LAST) begin
               cyc_d    = '0;
               state_d  = S_STOP;
               serial_d = 1'b1;
               stop_d   = '0;
            end else begin
               cyc_d = cyc_q + 12'd1;
            end
         end
         S_STOP: begin
            if (stop_q == STOP_LAST) begin
               if (!fifo_empty) begin
                  fifo_pop = 1'b1;
               end else begin
                  state_d  = S_IDLE;
                  active_d = 1'b0;
               end
            end else begin
               stop_d = stop_q + STOP_W'(1);
               // Raised one edge early so the registered pulse lands on the last stop cycle.
               done_d = (stop_q == STOP_PRE);
            end
         end
         default: begin
            state_d  = S_IDLE;
            serial_d = 1'b1;
            active_d = 1'b0;
         end
      endcase

      // A pop (from IDLE or the last stop cycle) always loads the next frame.
      if (fifo_pop) begin
         shift_d  = fifo_data;
         par_d    = (^fifo_data) ^ PAR_INV;
         cyc_d    = '0;
         bit_d    = '0;
         state_d  = S_START;
         serial_d = 1'b0;
         active_d = 1'b1;
      end
   end

   assign o_Tx_Serial = serial_q;
   assign o_Tx_Active = active_q;
   assign o_Tx_Done   = done_q;

endmodule
